spi_slave_burst: RTL and testbench

- Parametrised successor to the single-word SPI slave. Decodes 3-bit command frames of width-independent length from a clk-sampled SPI link.
- Drives a generic synchronous memory port (1-cycle read latency), so any RAM or register file can sit behind it.
- Adds in-frame burst writes and reads with address auto-increment, single-transaction reads (no second SS window), abort on early SS_n release, and illegal-command flagging.
- Sits between the SPI pins and the RAM inside the SPI wrapper.

---
 rtl/spi_pkg.sv | 36 +++
 rtl/spi_shift_reg.sv | 40 ++++
 rtl/spi_slave_burst.sv | 271 +++++++++++++++++++++++++++
 tb/tb_spi_slave_burst.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_pkg                                                      |
// | Description : Shared command/state encodings for the burst SPI slave.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package spi_pkg;

  localparam int CTRL_WIDTH = 3;
  localparam int RD_DUMMY   = 2;

  typedef enum logic [CTRL_WIDTH-1:0] {
    CMD_WR_ADDR = 3'b000,
    CMD_WR_DATA = 3'b001,
    CMD_RD_ADDR = 3'b110,
    CMD_RD_DATA = 3'b111
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD      = 3'd1,
    ST_ADDR     = 3'd2,
    ST_WDATA    = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_RD_SHIFT = 3'd5,
    ST_DRAIN    = 3'd6
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_shift_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_shift_reg                                                |
// | Description : MSB-first shift register: serial in, parallel load, serial   |
// |               out. Clear has priority over load, load over shift.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_sdi,
  output logic [WIDTH-1:0] o_data,
  output logic             o_sdo
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_clr) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
    end else if (i_shift) begin
      r_data <= {r_data[WIDTH-2:0], i_sdi};
    end
  end

  assign o_data = r_data;
  assign o_sdo  = r_data[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave_burst.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_slave_burst                                              |
// | Description : clk-sampled SPI slave with burst read/write to a generic     |
// |               synchronous memory port (1-cycle read latency).              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_slave_burst
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int BURST_EN   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  cmd_err
);

  // The final bit of any field is taken straight from mosi, so rx holds one bit less.
  localparam int RX_W  = max3(DATA_WIDTH, ADDR_WIDTH, CTRL_WIDTH) - 1;
  localparam int CNT_W = $clog2(RX_W + 1);

  localparam logic [CNT_W-1:0] c_cnt_cmd_last  = CNT_W'(CTRL_WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_addr_last = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_data_last = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_dummy     = CNT_W'(RD_DUMMY - 1);
  localparam logic [CNT_W-1:0] c_cnt_prefetch  = CNT_W'(DATA_WIDTH - 3);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [ADDR_WIDTH-1:0]   r_rd_addr;
  logic                    r_rd_sel;
  logic                    r_mem_req;
  logic                    r_mem_we;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;
  logic                    r_cmd_err;

  logic                    w_rx_shift;
  logic                    w_cnt_clr;
  logic                    w_cnt_inc;
  logic                    w_addr_commit;
  logic                    w_wr_commit;
  logic                    w_rd_req;
  logic                    w_tx_load;
  logic                    w_tx_shift;
  logic                    w_tx_clr;
  logic                    w_cmd_err;
  logic                    w_sel_load;
  logic                    w_sel_rd;

  logic [RX_W-1:0]         w_rx_q;
  logic                    w_rx_sdo_unused;
  logic [DATA_WIDTH-1:0]   w_tx_data_unused;
  logic [CTRL_WIDTH-1:0]   w_cmd;
  logic [ADDR_WIDTH-1:0]   w_addr_word;
  logic [DATA_WIDTH-1:0]   w_data_word;

  assign w_cmd       = {w_rx_q[CTRL_WIDTH-2:0], mosi};
  assign w_addr_word = {w_rx_q[ADDR_WIDTH-2:0], mosi};
  assign w_data_word = {w_rx_q[DATA_WIDTH-2:0], mosi};
  assign w_tx_clr    = (w_state_nxt != ST_RD_SHIFT);

  spi_shift_reg #(.WIDTH(RX_W)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (1'b0),
    .i_load      (1'b0),
    .i_shift     (w_rx_shift),
    .i_load_data ('0),
    .i_sdi       (mosi),
    .o_data      (w_rx_q),
    .o_sdo       (w_rx_sdo_unused)
  );

  spi_shift_reg #(.WIDTH(DATA_WIDTH)) u_tx (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_tx_clr),
    .i_load      (w_tx_load),
    .i_shift     (w_tx_shift),
    .i_load_data (mem_rdata),
    .i_sdi       (1'b0),
    .o_data      (w_tx_data_unused),
    .o_sdo       (miso)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_rx_shift    = 1'b0;
    w_cnt_clr     = 1'b0;
    w_cnt_inc     = 1'b0;
    w_addr_commit = 1'b0;
    w_wr_commit   = 1'b0;
    w_rd_req      = 1'b0;
    w_tx_load     = 1'b0;
    w_tx_shift    = 1'b0;
    w_cmd_err     = 1'b0;
    w_sel_load    = 1'b0;
    w_sel_rd      = 1'b0;
    if (ss_n) begin
      // Deselect drops any partial field; nothing on this edge is sampled.
      w_state_nxt = ST_IDLE;
      w_cnt_clr   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_CMD;
          w_rx_shift  = 1'b1;
          w_cnt_inc   = 1'b1;
        end
        ST_CMD: begin
          w_rx_shift = 1'b1;
          if (r_cnt == c_cnt_cmd_last) begin
            w_cnt_clr = 1'b1;
            case (cmd_e'(w_cmd))
              CMD_WR_ADDR: begin
                w_state_nxt = ST_ADDR;
                w_sel_load  = 1'b1;
              end
              CMD_RD_ADDR: begin
                w_state_nxt = ST_ADDR;
                w_sel_load  = 1'b1;
                w_sel_rd    = 1'b1;
              end
              CMD_WR_DATA: w_state_nxt = ST_WDATA;
              CMD_RD_DATA: begin
                w_state_nxt = ST_RD_WAIT;
                w_rd_req    = 1'b1;
              end
              default: begin
                w_state_nxt = ST_DRAIN;
                w_cmd_err   = 1'b1;
              end
            endcase
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        ST_ADDR: begin
          w_rx_shift = 1'b1;
          if (r_cnt == c_cnt_addr_last) begin
            w_addr_commit = 1'b1;
            w_cnt_clr     = 1'b1;
            w_state_nxt   = ST_DRAIN;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        ST_WDATA: begin
          w_rx_shift = 1'b1;
          if (r_cnt == c_cnt_data_last) begin
            w_wr_commit = 1'b1;
            w_cnt_clr   = 1'b1;
            if (BURST_EN == 0) begin
              w_state_nxt = ST_DRAIN;
            end
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        ST_RD_WAIT: begin
          if (r_cnt == c_cnt_dummy) begin
            w_tx_load   = 1'b1;
            w_cnt_clr   = 1'b1;
            w_state_nxt = ST_RD_SHIFT;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        ST_RD_SHIFT: begin
          if (r_cnt == c_cnt_data_last) begin
            w_cnt_clr = 1'b1;
            if (BURST_EN != 0) begin
              w_tx_load = 1'b1;
            end else begin
              w_state_nxt = ST_DRAIN;
            end
          end else begin
            w_tx_shift = 1'b1;
            w_cnt_inc  = 1'b1;
            // Prefetch so the next word's rdata lands exactly on the word boundary.
            if ((BURST_EN != 0) && (r_cnt == c_cnt_prefetch)) begin
              w_rd_req = 1'b1;
            end
          end
        end
        ST_DRAIN: w_state_nxt = ST_DRAIN;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_rd_sel    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_mem_req <= w_wr_commit | w_rd_req;
      r_cmd_err <= w_cmd_err;

      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_sel_load) begin
        r_rd_sel <= w_sel_rd;
      end

      if (w_wr_commit) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_wr_addr;
        r_mem_wdata <= w_data_word;
      end else if (w_rd_req) begin
        r_mem_we   <= 1'b0;
        r_mem_addr <= r_rd_addr;
      end

      // wr_addr advances as the write request retires, wrapping naturally.
      if (r_mem_req && r_mem_we) begin
        r_wr_addr <= r_wr_addr + 1'b1;
      end else if (w_addr_commit && !r_rd_sel) begin
        r_wr_addr <= w_addr_word;
      end

      if (w_tx_load) begin
        r_rd_addr <= r_rd_addr + 1'b1;
      end else if (w_addr_commit && r_rd_sel) begin
        r_rd_addr <= w_addr_word;
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cmd_err   = r_cmd_err;
  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_burst.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_slave_burst                                           |
// | Description : Directed self-checking bench for spi_slave_burst.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spi_slave_burst;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       cmd_err;

  int checks = 0;
  int errors = 0;
  int req_count = 0;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  spi_slave_burst #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .BURST_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .miso      (miso),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  // Synchronous RAM behind the slave; reset fills it with 0xEE.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'hEE;
      mem_rdata <= 8'h00;
    end else if (mem_req) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (mem_req) req_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input logic s, input logic b);
    @(negedge clk);
    ss_n = s;
    mosi = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) tick(1'b0, v[i]);
  endtask

  task automatic end_frame();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (miso !== 1'b0)    begin errors++; $display("FAIL reset_miso got %b exp 0", miso); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_req); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", cmd_err); end
    checks++; if ({mem_we, mem_addr, mem_wdata} !== 17'd0)
      begin errors++; $display("FAIL reset_memport got %h exp 0", {mem_we, mem_addr, mem_wdata}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    int c0;
    send_bits(3'b000, 3); send_bits(8'h3C, 8); end_frame();
    c0 = req_count;
    send_bits(3'b001, 3); send_bits(8'hA5 >> 1, 7);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL wr_early_req got %b exp 0", mem_req); end
    tick(1'b0, 1'b1);
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 8'h3C, 8'hA5})
      begin errors++; $display("FAIL wr_req got %h exp %h", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 8'h3C, 8'hA5}); end
    end_frame();
    checks++; if (mem[8'h3C] !== 8'hA5) begin errors++; $display("FAIL wr_mem got %h exp a5", mem[8'h3C]); end
    checks++; if (req_count - c0 !== 1) begin errors++; $display("FAIL wr_req_count got %0d exp 1", req_count - c0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy got %b exp 0", busy); end
  endtask

  task automatic test_single_read();
    logic [7:0] word = 8'h00;
    send_bits(3'b110, 3); send_bits(8'h3C, 8); end_frame();
    send_bits(3'b111, 3);
    checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 8'h3C})
      begin errors++; $display("FAIL rd_req got %h exp %h", {mem_req, mem_we, mem_addr}, {2'b10, 8'h3C}); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rd_dummy1 got %b exp 0", miso); end
    tick(1'b0, 1'b1);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rd_dummy2 got %b exp 0", miso); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rd_req_width got %b exp 0", mem_req); end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1);
      word = {word[6:0], miso};
    end
    checks++; if (word !== 8'hA5) begin errors++; $display("FAIL rd_word got %h exp a5", word); end
    end_frame();
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rd_miso_idle got %b exp 0", miso); end
  endtask

  task automatic test_burst_write();
    logic [7:0] words [3] = '{8'h11, 8'h22, 8'h33};
    logic [7:0] addrs [3] = '{8'hFE, 8'hFF, 8'h00};
    logic [7:0] w;
    send_bits(3'b000, 3); send_bits(8'hFE, 8); end_frame();
    send_bits(3'b001, 3);
    for (int i = 0; i < 3; i++) begin
      w = words[i];
      send_bits(w >> 1, 7);
      tick(1'b0, w[0]);
      checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, addrs[i], w})
        begin errors++; $display("FAIL bw_req%0d got %h exp %h", i, {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, addrs[i], w}); end
    end
    end_frame();
    checks++; if ({mem[8'hFE], mem[8'hFF], mem[8'h00]} !== 24'h112233)
      begin errors++; $display("FAIL bw_mem got %h exp 112233", {mem[8'hFE], mem[8'hFF], mem[8'h00]}); end
    send_bits(3'b001, 3); send_bits(8'h44 >> 1, 7); tick(1'b0, 1'b0);
    checks++; if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 8'h01, 8'h44})
      begin errors++; $display("FAIL bw_next_addr got %h exp %h", {mem_req, mem_addr, mem_wdata}, {1'b1, 8'h01, 8'h44}); end
    end_frame();
  endtask

  task automatic test_burst_read();
    logic [23:0] stream = 24'h0;
    send_bits(3'b110, 3); send_bits(8'hFE, 8); end_frame();
    send_bits(3'b111, 3);
    checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 8'hFE})
      begin errors++; $display("FAIL br_req got %h exp %h", {mem_req, mem_we, mem_addr}, {2'b10, 8'hFE}); end
    tick(1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      tick(1'b0, 1'b0);
      stream = {stream[22:0], miso};
    end
    checks++; if (stream !== 24'h112233) begin errors++; $display("FAIL br_stream got %h exp 112233", stream); end
    end_frame();
  endtask

  task automatic test_abort();
    int c0;
    send_bits(3'b000, 3); send_bits(8'h10, 8); end_frame();
    c0 = req_count;
    send_bits(3'b001, 3); send_bits(5'b01110, 5);
    tick(1'b1, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_busy got %b exp 0", busy); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL ab_req got %b exp 0", mem_req); end
    tick(1'b1, 1'b0);
    checks++; if (req_count - c0 !== 0) begin errors++; $display("FAIL ab_req_count got %0d exp 0", req_count - c0); end
    checks++; if (mem[8'h10] !== 8'hEE) begin errors++; $display("FAIL ab_mem got %h exp ee", mem[8'h10]); end
  endtask

  task automatic test_cmd_err();
    int c0;
    c0 = req_count;
    send_bits(3'b010, 3);
    checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL err_pulse got %b exp 1", cmd_err); end
    tick(1'b0, 1'b1);
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL err_width got %b exp 0", cmd_err); end
    send_bits(32'h0000_03FF, 10);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL err_drain_busy got %b exp 1", busy); end
    end_frame();
    checks++; if (req_count - c0 !== 0) begin errors++; $display("FAIL err_req_count got %0d exp 0", req_count - c0); end
    send_bits(3'b001, 3); send_bits(8'h5A >> 1, 7); tick(1'b0, 1'b0);
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 8'h10, 8'h5A})
      begin errors++; $display("FAIL err_recover got %h exp %h", {mem_req, mem_we, mem_addr, mem_wdata}, {2'b11, 8'h10, 8'h5A}); end
    end_frame();
  endtask

  task automatic test_reset_mid_read();
    send_bits(3'b110, 3); send_bits(8'h3C, 8); end_frame();
    send_bits(3'b111, 3);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL rr_pre_miso got %b exp 1", miso); end
    @(negedge clk);
    rst = 1'b1;
    ss_n = 1'b1;
    #1;
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rr_miso got %b exp 0", miso); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy got %b exp 0", busy); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rr_req got %b exp 0", mem_req); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_burst_write();
    test_burst_read();
    test_abort();
    test_cmd_err();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
